// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Parametrised UART receiver (majority-vote sampling, parity,
//            1/2 stop bits, break detection) feeding a ready/valid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_io,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_parity_err,
    output logic                          m_frame_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overrun,
    output logic                          break_det,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_CLK_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int c_MID         = c_CLK_PER_BIT / 2;
    localparam int c_CNT_W       = $clog2(c_CLK_PER_BIT);
    localparam int c_BIT_W       = $clog2(DATA_BITS);
    localparam int c_PTR_W       = $clog2(FIFO_DEPTH);
    localparam int c_ENTRY_W     = DATA_BITS + 2;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CLK_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_SMP_0    = c_CNT_W'(c_MID - 1);
    localparam logic [c_CNT_W-1:0] c_SMP_1    = c_CNT_W'(c_MID);
    localparam logic [c_CNT_W-1:0] c_SMP_2    = c_CNT_W'(c_MID + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT1     = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_BREAK  = 3'd5;

    // ------------------------------------------------------------------
    // Input synchronizer (idle-high line, so flops reset to 1)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_io;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver state and datapath
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BIT_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [1:0]           r_smp;
    logic                 r_par_bit;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_stop_idx;
    logic                 r_busy;

    logic w_cnt_last;
    logic w_decide;
    logic w_maj;
    logic w_final_stop;
    logic w_complete;
    logic w_zero_frame;
    logic w_is_break;
    logic w_push_req;
    logic w_par_exp;
    logic w_frame_err_final;

    assign w_cnt_last        = (r_cnt == c_CNT_LAST);
    assign w_decide          = (r_cnt == c_SMP_2);
    assign w_maj             = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rx_s) | (r_smp[1] & r_rx_s);
    assign w_final_stop      = (STOP_BITS == 1) || r_stop_idx;
    assign w_complete        = (r_state == c_ST_STOP) && w_final_stop && w_decide;
    // Break: all-zero data, zero parity bit (if any) and a low final stop bit
    assign w_zero_frame      = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && !w_maj;
    assign w_is_break        = w_complete && w_zero_frame;
    assign w_push_req        = w_complete && !w_zero_frame;
    assign w_par_exp         = (^r_shift) ^ (PARITY == 1);
    assign w_frame_err_final = r_frame_err | !w_maj;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!r_rx_s) w_state_nxt = c_ST_START;
            end
            c_ST_START: begin
                if (w_decide && w_maj)  w_state_nxt = c_ST_IDLE;
                else if (w_cnt_last)    w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_cnt_last && (r_bit_idx == c_BIT_LAST))
                    w_state_nxt = (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
            end
            c_ST_PARITY: begin
                if (w_cnt_last) w_state_nxt = c_ST_STOP;
            end
            c_ST_STOP: begin
                if (w_complete) w_state_nxt = w_zero_frame ? c_ST_BREAK : c_ST_IDLE;
            end
            c_ST_BREAK: begin
                if (r_rx_s) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_smp        <= '0;
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_stop_idx   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (r_state != c_ST_IDLE);

            // The start-detection cycle already counts as bit position 0
            if ((w_state_nxt == c_ST_IDLE) || (w_state_nxt == c_ST_BREAK))
                r_cnt <= '0;
            else if (r_state == c_ST_IDLE)
                r_cnt <= c_CNT_ONE;
            else if (w_cnt_last)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_CNT_ONE;

            if (r_cnt == c_SMP_0) r_smp[0] <= r_rx_s;
            if (r_cnt == c_SMP_1) r_smp[1] <= r_rx_s;

            case (r_state)
                c_ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_bit_idx    <= '0;
                        r_par_bit    <= 1'b0;
                        r_parity_err <= 1'b0;
                        r_frame_err  <= 1'b0;
                        r_stop_idx   <= 1'b0;
                    end
                end
                c_ST_DATA: begin
                    if (w_decide)   r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                    if (w_cnt_last) r_bit_idx <= r_bit_idx + c_BIT_ONE;
                end
                c_ST_PARITY: begin
                    if (w_decide) begin
                        r_par_bit    <= w_maj;
                        r_parity_err <= w_maj ^ w_par_exp;
                    end
                end
                c_ST_STOP: begin
                    if (!w_final_stop) begin
                        if (w_decide && !w_maj) r_frame_err <= 1'b1;
                        if (w_cnt_last)         r_stop_idx  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;

    assign m_valid = (r_count != '0);
    assign w_pop   = m_valid && m_ready;
    assign w_full  = (r_count == c_FULL);
    // A same-cycle pop frees the slot the incoming frame needs
    assign w_push  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_shift, r_parity_err, w_frame_err_final};
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT1;
                2'b01:   r_count <= r_count - c_CNT1;
                default: ;
            endcase
        end
    end

    assign {m_data, m_parity_err, m_frame_err} = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign busy       = r_busy;
    assign overrun    = w_push_req && !w_push;
    assign break_det  = w_is_break;

endmodule
`default_nettype wire
